// File: rtl/iq_pair_fifo_pkg.sv
// iq_pair_fifo shared definitions.
// Packed I/Q field positions and pairing phase encoding.
package iq_pair_fifo_pkg;

    localparam int ISZ_DEF = 16;
    localparam int AW_DEF  = 4;
    localparam int CW_DEF  = 16;

    localparam int IQ_WORD_W = 2 * ISZ_DEF;

    // Field positions inside the packed word, shared with the transport side
    localparam int I_MSB = IQ_WORD_W - 1;
    localparam int I_LSB = ISZ_DEF;
    localparam int Q_MSB = ISZ_DEF - 1;
    localparam int Q_LSB = 0;

    typedef enum logic {
        PH_Q = 1'b0,
        PH_I = 1'b1
    } phase_e;

    function automatic logic [IQ_WORD_W-1:0] pack_iq(
        input logic [ISZ_DEF-1:0] i_word,
        input logic [ISZ_DEF-1:0] q_word
    );
        return {i_word, q_word};
    endfunction

endpackage

// File: rtl/iq_pair_fifo_if.sv
// iq_pair_fifo stream and status bundle.
// The master drives the sample stream and consumer side; the slave is the block.
interface iq_pair_fifo_if
    import iq_pair_fifo_pkg::*;
#(
    parameter int ISZ = ISZ_DEF,
    parameter int AW  = AW_DEF,
    parameter int CW  = CW_DEF
) ();

    logic             in_valid;
    logic [ISZ-1:0]   in;
    logic             out_valid;
    logic             out_ready;
    logic [2*ISZ-1:0] out;
    logic [AW:0]      level;
    logic             overflow;
    logic [CW-1:0]    ovf_count;
    logic             clear_ovf;

    modport master (
        output in_valid,
        output in,
        output out_ready,
        output clear_ovf,
        input  out_valid,
        input  out,
        input  level,
        input  overflow,
        input  ovf_count
    );

    modport slave (
        input  in_valid,
        input  in,
        input  out_ready,
        input  clear_ovf,
        output out_valid,
        output out,
        output level,
        output overflow,
        output ovf_count
    );

endinterface

// File: rtl/iq_pair_fifo_sync_fifo_fwft.sv
// First-word-fall-through FIFO over an async-read array.
// Caller guarantees no push when full without pop and no pop when empty.
module sync_fifo_fwft #(
    parameter int AW = 4,
    parameter int W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  level_o
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case (1'b1)
            push_i && !pop_i: level_d = level_q + (AW+1)'(1);
            pop_i && !push_i: level_d = level_q - (AW+1)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (level_q == DEPTH);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/iq_pair_fifo.sv
// Pairs a Q,I word stream into {I,Q} words and buffers them.
// Counts pairs dropped while the buffer is full and not draining.
module iq_pair_fifo
    import iq_pair_fifo_pkg::*;
#(
    parameter int ISZ = ISZ_DEF,
    parameter int AW  = AW_DEF,
    parameter int CW  = CW_DEF
) (
    input logic         clk,
    input logic         reset,
    iq_pair_fifo_if.slave bus
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    phase_e         ph_q, ph_d;
    logic [ISZ-1:0] hold_q, hold_d;
    logic           hold_en;
    logic           wr_req;

    logic           push, pop, drop;
    logic           full, empty;

    logic           ovf_q, ovf_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q <= PH_Q;
        end else begin
            ph_q <= ph_d;
        end
    end

    always_comb begin
        ph_d = ph_q;
        if (bus.in_valid) begin
            unique case (ph_q)
                PH_Q:    ph_d = PH_I;
                PH_I:    ph_d = PH_Q;
                default: ph_d = PH_Q;
            endcase
        end
    end

    always_comb begin
        hold_en = 1'b0;
        wr_req  = 1'b0;
        if (bus.in_valid) begin
            unique case (ph_q)
                PH_Q:    hold_en = 1'b1;
                PH_I:    wr_req  = 1'b1;
                default: ;
            endcase
        end
    end

    assign hold_d = hold_en ? bus.in : hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // A pop frees the slot on the same edge, so a full FIFO still accepts
    assign pop  = !empty && bus.out_ready;
    assign push = wr_req && (!full || pop);
    assign drop = wr_req && full && !pop;

    sync_fifo_fwft #(
        .AW (AW),
        .W  (2*ISZ)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i ({bus.in, hold_q}),
        .pop_i   (pop),
        .rdata_o (bus.out),
        .full_o  (full),
        .empty_o (empty),
        .level_o (bus.level)
    );

    always_comb begin
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        unique case (1'b1)
            drop && bus.clear_ovf: begin
                ovf_d = 1'b1;
                cnt_d = CW'(1);
            end
            drop && !bus.clear_ovf: begin
                ovf_d = 1'b1;
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            end
            !drop && bus.clear_ovf: begin
                ovf_d = 1'b0;
                cnt_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.out_valid = !empty;
    assign bus.overflow  = ovf_q;
    assign bus.ovf_count = cnt_q;

endmodule

// File: tb/tb_iq_pair_fifo.sv
// Bench for iq_pair_fifo: directed scenarios plus a random run
// against a queue-based reference of the pairing and overflow rules.
module tb_iq_pair_fifo;
    import iq_pair_fifo_pkg::*;

    localparam int ISZ   = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (1 << CW) - 1;

    typedef logic [2*ISZ-1:0] word_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    iq_pair_fifo_if #(.ISZ(ISZ), .AW(AW), .CW(CW)) bus ();

    iq_pair_fifo #(.ISZ(ISZ), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    word_t          mq[$];
    bit             m_have_q;
    logic [ISZ-1:0] m_hold;
    bit             m_ovf;
    int             m_cnt;
    word_t          got[$];

    // Drive one cycle, advance the reference, sample 1 time unit after the edge
    task automatic step(input bit v, input logic [ISZ-1:0] d,
                        input bit rdy, input bit clr, input bit rst = 1'b0);
        bit pop, push, drop;
        bus.in_valid  = v;
        bus.in        = d;
        bus.out_ready = rdy;
        bus.clear_ovf = clr;
        reset         = rst;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_have_q = 0;
            m_ovf    = 0;
            m_cnt    = 0;
        end else begin
            pop  = rdy && (mq.size() != 0);
            push = 0;
            drop = 0;
            if (v && m_have_q) begin
                if (mq.size() < DEPTH || pop) push = 1;
                else drop = 1;
            end
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(pack_iq(d, m_hold));
            if (v) begin
                if (!m_have_q) m_hold = d;
                m_have_q = !m_have_q;
            end
            if (drop) begin
                m_ovf = 1;
                m_cnt = clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
            end else if (clr) begin
                m_ovf = 0;
                m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic send_pair(input logic [ISZ-1:0] q, input logic [ISZ-1:0] i,
                             input bit rdy, input bit clr_on_i);
        step(1, q, rdy, 0);
        step(1, i, rdy, clr_on_i);
    endtask

    task automatic drain();
        got.delete();
        for (int n = 0; n < 3 * DEPTH && bus.out_valid; n++) begin
            got.push_back(bus.out);
            step(0, '0, 1, 0);
        end
    endtask

    task automatic test_reset();
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.level !== '0) begin
            errors++;
            $display("FAIL reset_fifo: valid=%b level=%0d want 0/0",
                     bus.out_valid, bus.level);
        end
        checks++;
        if (bus.overflow !== 1'b0 || bus.ovf_count !== '0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b cnt=%0d want 0/0",
                     bus.overflow, bus.ovf_count);
        end
    endtask

    task automatic test_first_pair();
        step(1, 16'h1111, 0, 0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL half_pair_valid: got %b want 0", bus.out_valid);
        end
        step(1, 16'h2222, 0, 0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 32'h2222_1111
            || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL first_pair: v=%b out=%h lvl=%0d want 1/22221111/1",
                     bus.out_valid, bus.out, bus.level);
        end
        for (int n = 0; n < 10; n++) begin
            step(0, '0, 0, 0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== 32'h2222_1111) begin
                errors++;
                $display("FAIL stall_hold[%0d]: v=%b out=%h want 1/22221111",
                         n, bus.out_valid, bus.out);
            end
        end
        step(0, '0, 1, 0);
        checks++;
        if (bus.level !== '0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_drain: lvl=%0d v=%b want 0/0",
                     bus.level, bus.out_valid);
        end
    endtask

    task automatic test_signed_gaps();
        word_t exp;
        got.delete();
        for (int k = 0; k < 8; k++) begin
            step(1, 16'h8000 + 16'(k), 1, 0);
            if (bus.out_valid) got.push_back(bus.out);
            repeat ($urandom_range(0, 3)) begin
                step(0, '0, 1, 0);
                if (bus.out_valid) got.push_back(bus.out);
            end
            step(1, 16'h7FFF - 16'(k), 1, 0);
            if (bus.out_valid) got.push_back(bus.out);
            repeat ($urandom_range(0, 3)) begin
                step(0, '0, 1, 0);
                if (bus.out_valid) got.push_back(bus.out);
            end
        end
        for (int n = 0; n < 10; n++) begin
            step(0, '0, 1, 0);
            if (bus.out_valid) got.push_back(bus.out);
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL signed_count: got %0d words want 8", got.size());
        end
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            exp = {16'h7FFF - 16'(k), 16'h8000 + 16'(k)};
            checks++;
            if (got[k] !== exp) begin
                errors++;
                $display("FAIL signed_word[%0d]: got %h want %h", k, got[k], exp);
            end
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 18; k++) begin
            send_pair(16'h1000 + 16'(k), 16'h2000 + 16'(k), 0, 0);
        end
        checks++;
        if (bus.level !== 5'd16 || bus.overflow !== 1'b1
            || bus.ovf_count !== 5'd2) begin
            errors++;
            $display("FAIL ovf_full: lvl=%0d ovf=%b cnt=%0d want 16/1/2",
                     bus.level, bus.overflow, bus.ovf_count);
        end
        drain();
        checks++;
        if (got.size() != 16 || bus.level !== '0) begin
            errors++;
            $display("FAIL ovf_drain: words=%0d lvl=%0d want 16/0",
                     got.size(), bus.level);
        end
        for (int k = 0; k < 16 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== {16'h2000 + 16'(k), 16'h1000 + 16'(k)}) begin
                errors++;
                $display("FAIL ovf_word[%0d]: got %h want %h", k, got[k],
                         {16'h2000 + 16'(k), 16'h1000 + 16'(k)});
            end
        end
        step(0, '0, 0, 1);
        checks++;
        if (bus.overflow !== 1'b0 || bus.ovf_count !== '0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b cnt=%0d want 0/0",
                     bus.overflow, bus.ovf_count);
        end
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 16; k++) begin
            send_pair(16'h3000 + 16'(k), 16'h4000 + 16'(k), 0, 0);
        end
        step(1, 16'h5A5A, 0, 0);
        step(1, 16'hA5A5, 1, 0);
        checks++;
        if (bus.level !== 5'd16 || bus.overflow !== 1'b0
            || bus.ovf_count !== '0) begin
            errors++;
            $display("FAIL full_pp: lvl=%0d ovf=%b cnt=%0d want 16/0/0",
                     bus.level, bus.overflow, bus.ovf_count);
        end
        checks++;
        if (bus.out !== 32'h4001_3001) begin
            errors++;
            $display("FAIL full_pp_head: got %h want 40013001", bus.out);
        end
        drain();
        checks++;
        if (got.size() != 16 || got[got.size()-1] !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL full_pp_tail: words=%0d want 16 ending a5a55a5a",
                     got.size());
        end
    endtask

    task automatic test_clear_collide();
        for (int k = 0; k < 16; k++) begin
            send_pair(16'(k), 16'(k + 100), 0, 0);
        end
        send_pair(16'hDEAD, 16'hBEEF, 0, 0);
        send_pair(16'hCAFE, 16'hF00D, 0, 1);
        checks++;
        if (bus.overflow !== 1'b1 || bus.ovf_count !== 5'd1) begin
            errors++;
            $display("FAIL clear_collide: ovf=%b cnt=%0d want 1/1",
                     bus.overflow, bus.ovf_count);
        end
        step(0, '0, 0, 1);
        checks++;
        if (bus.overflow !== 1'b0 || bus.ovf_count !== '0) begin
            errors++;
            $display("FAIL clear_alone: ovf=%b cnt=%0d want 0/0",
                     bus.overflow, bus.ovf_count);
        end
        drain();
    endtask

    task automatic test_reset_midpair();
        send_pair(16'h0001, 16'h0002, 0, 0);
        step(1, 16'h1234, 0, 0);
        step(0, '0, 0, 0, 1);
        checks++;
        if (bus.level !== '0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: lvl=%0d v=%b want 0/0",
                     bus.level, bus.out_valid);
        end
        step(1, 16'hAAAA, 0, 0);
        step(1, 16'h5555, 0, 0);
        checks++;
        if (bus.out !== 32'h5555_AAAA || bus.level !== 5'd1) begin
            errors++;
            $display("FAIL mid_realign: out=%h lvl=%0d want 5555aaaa/1",
                     bus.out, bus.level);
        end
        drain();
    endtask

    task automatic test_saturate();
        int exp;
        for (int k = 0; k < 16; k++) begin
            send_pair(16'(k), 16'(k), 0, 0);
        end
        for (int n = 1; n <= CMAX + 3; n++) begin
            send_pair(16'hEEEE, 16'hFFFF, 0, 0);
            exp = (n < CMAX) ? n : CMAX;
            checks++;
            if (bus.ovf_count !== CW'(exp) || bus.overflow !== 1'b1) begin
                errors++;
                $display("FAIL saturate[%0d]: cnt=%0d ovf=%b want %0d/1",
                         n, bus.ovf_count, bus.overflow, exp);
            end
        end
        drain();
        step(0, '0, 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 199) == 0);
            checks++;
            if (bus.out_valid !== (mq.size() != 0)
                || bus.level !== (AW+1)'(mq.size())) begin
                errors++;
                $display("FAIL rnd_level[%0d]: v=%b lvl=%0d want %0d",
                         n, bus.out_valid, bus.level, mq.size());
            end
            checks++;
            if (bus.overflow !== m_ovf || bus.ovf_count !== CW'(m_cnt)) begin
                errors++;
                $display("FAIL rnd_ovf[%0d]: ovf=%b cnt=%0d want %b/%0d",
                         n, bus.overflow, bus.ovf_count, m_ovf, m_cnt);
            end
            if (mq.size() != 0) begin
                checks++;
                if (bus.out !== mq[0]) begin
                    errors++;
                    $display("FAIL rnd_out[%0d]: got %h want %h",
                             n, bus.out, mq[0]);
                end
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        bus.clear_ovf = 1'b0;
        test_reset();
        test_first_pair();
        test_signed_gaps();
        test_overflow();
        test_full_push_pop();
        test_clear_collide();
        test_reset_midpair();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_pair_fifo.md
Name: iq_pair_fifo

Overview:
- Sits directly downstream of the I/Q FIR decimator.
- Consumes its 16-bit word stream, which carries Q then I for each decimated sample, and pairs each Q/I couple into one 32-bit {I,Q} word.
- Buffers the packed words in a small FIFO and hands them to the host-side transport with a valid/ready handshake.
- Detects and counts overflow when the consumer stalls.

Parameters:
- ISZ, 16, width of one I or Q input word.
- AW, 4, FIFO address width; depth = 2^AW packed words.
- CW, 16, overflow counter width.

Ports:
- clk  input  1  clock, single domain
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input word strobe, one word per cycle maximum
- in  input  ISZ  signed input word: Q first, then I, alternating
- out_valid  output  1  FIFO head holds a valid packed word
- out_ready  input  1  consumer accepts the head this cycle
- out  output  2*ISZ  packed word: out[2*ISZ-1:ISZ] = I, out[ISZ-1:0] = Q
- level  output  AW+1  number of packed words currently stored (0..2^AW)
- overflow  output  1  sticky flag: at least one pair has been dropped
- ovf_count  output  CW  count of dropped pairs, saturating at 2^CW-1
- clear_ovf  input  1  single-cycle clear of overflow and ovf_count

Behaviour:
- The block has one clock and uses a synchronous, active-high reset.
- Reset values: out_valid=0, level=0, overflow=0, ovf_count=0, phase=Q, read/write pointers=0. out is don't-care while out_valid=0.
- Reset in the middle of operation discards any half-built pair and all stored words. The first in_valid after reset is always treated as Q.
- Pairing state machine, two states, advanced only on in_valid:
  - PH_Q: latch in into q_hold, go to PH_I.
  - PH_I: form {in, q_hold}, issue a write request, go to PH_Q.
  - A cycle with in_valid=0 holds the current state.
- Write is accepted when (level != 2^AW) OR (pop this cycle).
  - Simultaneous push and pop when full is therefore legal, and level stays at 2^AW.
- Pop occurs when out_valid && out_ready.
  - out_ready while empty is ignored.
- level update per edge: +1 for push only, -1 for pop only, unchanged for both or neither.
- FIFO storage uses an asynchronous-read array (distributed RAM). out = mem[rd_ptr].
  - out_valid = (level != 0) is registered through level, so no extra register stage is needed.
  - Latency: I word sampled at edge N gives out_valid=1 and the packed word at out from cycle N+1, when the FIFO was empty.
- out and out_valid must stay stable while out_valid=1 and out_ready=0.
- Pointers wrap modulo 2^AW. No special case at wrap.
- Overflow: a write request that is not accepted drops the whole pair.
  - On that edge, overflow is set to 1 and ovf_count increments, holding at 2^CW-1.
  - The phase still returns to PH_Q, so alignment is kept.
- clear_ovf sets overflow=0 and ovf_count=0.
  - If a drop occurs on the same edge, the drop wins: overflow=1, ovf_count=1.
- No arithmetic is performed on sample values. Bits are concatenated unchanged and sign is preserved.

Decomposition:
- Shared package holds:
  - IQ_WORD_W = 2*ISZ
  - Packed-field localparams I_MSB, I_LSB, Q_MSB, Q_LSB, shared with the transport consumer
  - Phase encoding constants PH_Q=1'b0, PH_I=1'b1
- Natural sub-module: sync_fifo_fwft (AW and width parameters; push, pop, full, empty, level). The pairing logic and overflow logic stay in the top level.

Test Plan:
- Reset, then in_valid with in=0x1111 (Q) then 0x2222 (I) on consecutive cycles, out_ready=0 -> one cycle after the I word: out_valid=1, out=0x22221111, level=1. out is held unchanged for 10 stall cycles.
- Eight pairs Q=0x8000+k, I=0x7FFF-k (k=0..7) with gaps of random length between words, out_ready=1 -> eight outputs in order, each out = {0x7FFF-k, 0x8000+k}, with signs intact.
- AW=4, out_ready=0, push 18 pairs -> level=16, overflow=1, ovf_count=2. Then drain with out_ready=1 -> exactly pairs 0..15 come out, and level returns to 0.
- With the FIFO full, present an I word and out_ready=1 on the same cycle -> pair accepted, head popped, level stays 16, ovf_count does not change.
- Assert clear_ovf on the same cycle as a dropped pair -> overflow=1, ovf_count=1. Assert clear_ovf alone on the next cycle -> overflow=0, ovf_count=0.
- Send a Q word only, assert reset for 1 cycle, then send Q=0xAAAA and I=0x5555 -> out=0x5555AAAA, showing the half-pair was discarded. Also force ovf_count to 2^CW-1 and then drop one more pair -> the count stays saturated.
